// File: rtl/add_arbiter_pkg.sv
// Shared constants, response-stage state and index helper for the shared-adder arbiter.
package add_arbiter_pkg;

    localparam int W_DEFAULT    = 8;
    localparam int NREQ_DEFAULT = 4;

    typedef enum logic {
        RSP_EMPTY = 1'b0,
        RSP_FULL  = 1'b1
    } rsp_state_e;

    // Rotating increment: idx+1 wrapping back to 0 at n.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        if (idx + 32'd1 >= n) begin
            return 32'd0;
        end else begin
            return idx + 32'd1;
        end
    endfunction

endpackage

// File: rtl/add_arbiter_rr_pick.sv
// Combinational round-robin winner search starting at the priority pointer.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [IDW-1:0]  winner_o,
    output logic            any_valid_o
);

    // Scan offsets from farthest to nearest so the nearest valid requester is written last.
    always_comb begin
        int idx;
        idx         = 0;
        winner_o    = '0;
        any_valid_o = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (32'(ptr_i) + k) % NREQ;
            if (req_i[idx]) begin
                winner_o    = IDW'(idx);
                any_valid_o = 1'b1;
            end else begin
                any_valid_o = any_valid_o;
            end
        end
    end

endmodule

// File: rtl/add_arbiter.sv
// Round-robin sharing of one W-bit adder between NREQ requesters with a one-entry response stage.
module add_arbiter
    import add_arbiter_pkg::*;
#(
    parameter int W    = W_DEFAULT,
    parameter int NREQ = NREQ_DEFAULT,
    parameter int IDW  = $clog2(NREQ),
    parameter int SAT  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [W-1:0]      rsp_sum,
    output logic              rsp_carry,
    output logic [IDW-1:0]    rsp_id
);

    rsp_state_e       state_q;
    logic [W-1:0]     sum_q;
    logic             carry_q;
    logic [IDW-1:0]   id_q;
    logic [IDW-1:0]   rr_ptr_q;
    logic [IDW-1:0]   rr_ptr_d;

    logic [IDW-1:0]   winner_s;
    logic             any_valid_s;
    logic             can_accept_s;
    logic             xfer_s;
    logic [W-1:0]     opa_s;
    logic [W-1:0]     opb_s;
    logic [W:0]       full_sum_s;
    logic [W-1:0]     sat_sum_s;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req_i       (req_valid),
        .ptr_i       (rr_ptr_q),
        .winner_o    (winner_s),
        .any_valid_o (any_valid_s)
    );

    assign can_accept_s = ena && ((state_q == RSP_EMPTY) || rsp_ready);
    assign xfer_s       = can_accept_s && any_valid_s;
    assign opa_s        = req_a[32'(winner_s) * W +: W];
    assign opb_s        = req_b[32'(winner_s) * W +: W];
    assign full_sum_s   = {1'b0, opa_s} + {1'b0, opb_s};
    assign rr_ptr_d     = IDW'(rr_next(32'(winner_s), 32'(NREQ)));

    // Grant only the winner, and only when the response stage can take its result.
    always_comb begin
        req_ready = '0;
        if (xfer_s) begin
            req_ready[winner_s] = 1'b1;
        end else begin
            req_ready = '0;
        end
    end

    // Saturation is applied after the carry has been computed from the full-width add.
    always_comb begin
        if ((SAT != 0) && full_sum_s[W]) begin
            sat_sum_s = '1;
        end else begin
            sat_sum_s = full_sum_s[W-1:0];
        end
    end

    // Response stage FSM with its data fields and the priority pointer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= RSP_EMPTY;
            sum_q    <= '0;
            carry_q  <= 1'b0;
            id_q     <= '0;
            rr_ptr_q <= '0;
        end else begin
            case (state_q)
                RSP_EMPTY, RSP_FULL: begin
                    if (xfer_s) begin
                        // A transfer also covers the drain-and-refill case: no bubble.
                        state_q  <= RSP_FULL;
                        sum_q    <= sat_sum_s;
                        carry_q  <= full_sum_s[W];
                        id_q     <= winner_s;
                        rr_ptr_q <= rr_ptr_d;
                    end else if ((state_q == RSP_FULL) && rsp_ready) begin
                        state_q <= RSP_EMPTY;
                    end else begin
                        state_q <= state_q;
                    end
                end
                default: begin
                    state_q <= RSP_EMPTY;
                end
            endcase
        end
    end

    assign rsp_valid = (state_q == RSP_FULL);
    assign rsp_sum   = sum_q;
    assign rsp_carry = carry_q;
    assign rsp_id    = id_q;

endmodule

// File: tb/tb_add_arbiter.sv
// Directed-vector bench for add_arbiter: wrap and saturating instances share stimulus and a behavioural model.
module tb_add_arbiter;

    localparam int W    = 8;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic              clk;
    logic              rst_n;
    logic              ena;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic              rsp_ready;

    logic [NREQ-1:0]   rdy0, rdy1;
    logic              val0, val1;
    logic [W-1:0]      sum0, sum1;
    logic              car0, car1;
    logic [IDW-1:0]    id0, id1;

    int checks;
    int errors;
    bit check_en;

    // Behavioural model of the response stage and priority pointer
    bit m_valid;
    int m_sum;
    int m_sat;
    int m_carry;
    int m_id;
    int m_ptr;

    add_arbiter #(.W(W), .NREQ(NREQ), .IDW(IDW), .SAT(0)) u_dut_wrap (
        .clk(clk), .rst_n(rst_n), .ena(ena), .req_valid(req_valid),
        .req_a(req_a), .req_b(req_b), .req_ready(rdy0), .rsp_valid(val0),
        .rsp_ready(rsp_ready), .rsp_sum(sum0), .rsp_carry(car0), .rsp_id(id0)
    );

    add_arbiter #(.W(W), .NREQ(NREQ), .IDW(IDW), .SAT(1)) u_dut_sat (
        .clk(clk), .rst_n(rst_n), .ena(ena), .req_valid(req_valid),
        .req_a(req_a), .req_b(req_b), .req_ready(rdy1), .rsp_valid(val1),
        .rsp_ready(rsp_ready), .rsp_sum(sum1), .rsp_carry(car1), .rsp_id(id1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        checks = checks + 1;
        if (got != exp) begin
            errors = errors + 1;
            $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // First valid requester scanning from the pointer, or -1 if none.
    function automatic int find_winner(input logic [NREQ-1:0] v, input int ptr);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic int model_ready();
        int w;
        bit can;
        can = ena && (!m_valid || rsp_ready);
        w   = find_winner(req_valid, m_ptr);
        if (can && w >= 0) return 1 << w;
        return 0;
    endfunction

    // Advance the model on each rising edge from the inputs present at that edge.
    always @(posedge clk) begin
        int w;
        int a;
        int b;
        int s;
        if (!rst_n) begin
            m_valid = 1'b0; m_sum = 0; m_sat = 0; m_carry = 0; m_id = 0; m_ptr = 0;
        end else begin
            w = find_winner(req_valid, m_ptr);
            if (ena && (!m_valid || rsp_ready) && w >= 0) begin
                a       = int'(req_a[w*W +: W]);
                b       = int'(req_b[w*W +: W]);
                s       = a + b;
                m_carry = (s > 255) ? 1 : 0;
                m_sum   = s % 256;
                m_sat   = (s > 255) ? 255 : s;
                m_id    = w;
                m_valid = 1'b1;
                m_ptr   = (w + 1) % NREQ;
            end else if (m_valid && rsp_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    // Compare both instances against the model every cycle, away from the rising edge.
    always @(negedge clk) begin
        if (check_en) begin
            check("req_ready_wrap", int'(rdy0), model_ready());
            check("req_ready_sat",  int'(rdy1), model_ready());
            check("rsp_valid_wrap", int'(val0), int'(m_valid));
            check("rsp_valid_sat",  int'(val1), int'(m_valid));
            check("rsp_sum_wrap",   int'(sum0), m_sum);
            check("rsp_sum_sat",    int'(sum1), m_sat);
            check("rsp_carry_wrap", int'(car0), m_carry);
            check("rsp_carry_sat",  int'(car1), m_carry);
            check("rsp_id_wrap",    int'(id0),  m_id);
            check("rsp_id_sat",     int'(id1),  m_id);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    logic [1:0] rr_ids [6];
    logic [3:0] mix_valid [10];
    logic       mix_ready [10];
    logic       mix_ena   [10];

    initial begin
        checks = 0; errors = 0; check_en = 1'b0;
        m_valid = 1'b0; m_sum = 0; m_sat = 0; m_carry = 0; m_id = 0; m_ptr = 0;
        rst_n = 1'b0; ena = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
        rr_ids    = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        mix_valid = '{4'b0110, 4'b0100, 4'b0000, 4'b1001, 4'b1001, 4'b0011, 4'b1111, 4'b1000, 4'b0101, 4'b0000};
        mix_ready = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        mix_ena   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        tick();
        check_en = 1'b1;
        tick();
        check("reset_valid", int'(val0), 0);
        check("reset_sum", int'(sum0), 0);
        check("reset_id", int'(id0), 0);

        // Single requester
        rst_n = 1'b1;
        set_op(1, 8'h12, 8'h34);
        req_valid = 4'b0010; rsp_ready = 1'b1;
        #1 check("single_ready", int'(rdy0), 4'b0010);
        tick();
        req_valid = 4'b0000;
        check("single_valid", int'(val0), 1);
        check("single_sum", int'(sum0), 8'h46);
        check("single_carry", int'(car0), 0);
        check("single_id", int'(id0), 1);
        tick();

        // Overflow, wrapping and saturating instances
        set_op(0, 8'hF0, 8'h20);
        req_valid = 4'b0001;
        tick();
        req_valid = 4'b0000;
        check("ovf_sum_wrap", int'(sum0), 8'h10);
        check("ovf_carry_wrap", int'(car0), 1);
        check("ovf_sum_sat", int'(sum1), 8'hFF);
        check("ovf_carry_sat", int'(car1), 1);
        tick();

        // Round robin from a fresh reset
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < NREQ; i++) set_op(i, 8'(i + 1), 8'(16 * i));
        req_valid = 4'b1111; rsp_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1 check("rr_ready", int'(rdy0), 1 << rr_ids[k]);
            tick();
            check("rr_valid", int'(val0), 1);
            check("rr_id", int'(id0), int'(rr_ids[k]));
        end

        // Backpressure while FULL with requester 1's result (2 + 0x10)
        rsp_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1 check("bp_ready", int'(rdy0), 0);
            tick();
            check("bp_valid", int'(val0), 1);
            check("bp_id", int'(id0), 1);
            check("bp_sum", int'(sum0), 8'h12);
        end
        rsp_ready = 1'b1;
        #1 check("bp_release_ready", int'(rdy0), 4'b0100);
        tick();
        check("bp_release_valid", int'(val0), 1);
        check("bp_release_id", int'(id0), 2);

        // ena low: no grants, drain still allowed, pointer held at 3
        ena = 1'b0; rsp_ready = 1'b0;
        #1 check("ena_ready", int'(rdy0), 0);
        tick();
        rsp_ready = 1'b1;
        tick();
        check("ena_drain", int'(val0), 0);
        tick();
        check("ena_still_empty", int'(val0), 0);
        ena = 1'b1;
        #1 check("ena_ptr_held", int'(rdy0), 4'b1000);
        tick();
        check("ena_resume_id", int'(id0), 3);

        // Reset while FULL with id 2
        req_valid = 4'b0100;
        tick();
        check("pre_rst_id", int'(id0), 2);
        rsp_ready = 1'b0;
        rst_n = 1'b0;
        tick();
        check("mid_rst_valid", int'(val0), 0);
        check("mid_rst_sum", int'(sum0), 0);
        check("mid_rst_id", int'(id0), 0);
        rst_n = 1'b1; req_valid = 4'b1111; rsp_ready = 1'b1;
        #1 check("post_rst_ready", int'(rdy0), 4'b0001);
        tick();
        check("post_rst_id", int'(id0), 0);

        // Mixed traffic with dropped valids, backpressure and ena gaps
        for (int i = 0; i < NREQ; i++) set_op(i, 8'(8'h55 + 37 * i), 8'(8'hA0 + 11 * i));
        for (int k = 0; k < 10; k++) begin
            req_valid = mix_valid[k]; rsp_ready = mix_ready[k]; ena = mix_ena[k];
            tick();
        end
        req_valid = '0; ena = 1'b1; rsp_ready = 1'b1;
        tick();
        tick();

        check_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
